// File: rtl/relu_pool_if.sv
// -----------------------------------------------------------------------------
// relu_pool_if
// Bundle of the load/data/status/result signals between the convolution layer
// side (master) and the ReLU + 1x2 max-pool stage (slave).
//   load  : start pulse from the producer
//   d     : CH x ROWS x COLS signed input map, channel-major, row-major
//   busy  : stage is working through its channels
//   valid : q holds a complete pooled map
//   q     : CH x ROWS x (COLS/2) pooled output map, same ordering as d
// -----------------------------------------------------------------------------
interface relu_pool_if #(
    parameter int DATA_LEN = 16,
    parameter int CH       = 32,
    parameter int ROWS     = 3,
    parameter int COLS     = 4
);
    localparam int IN_W  = CH * ROWS * COLS * DATA_LEN;
    localparam int OUT_W = CH * ROWS * (COLS / 2) * DATA_LEN;

    logic             load;
    logic [IN_W-1:0]  d;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] q;

    modport master (
        output load,
        output d,
        input  busy,
        input  valid,
        input  q
    );

    modport slave (
        input  load,
        input  d,
        output busy,
        output valid,
        output q
    );
endinterface

// File: rtl/relu_pool.sv
// -----------------------------------------------------------------------------
// relu_pool
// ReLU followed by 1x2 horizontal max pooling over a CH-channel ROWS x COLS
// feature map. On an accepted load the whole input map is captured, then one
// channel is processed per clock; after CH clocks the pooled map is presented
// with a level valid that holds until the next accepted load or reset.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : relu_pool_if slave (load, d in; busy, valid, q out)
// -----------------------------------------------------------------------------
module relu_pool #(
    parameter int DATA_LEN = 16,
    parameter int CH       = 32,
    parameter int ROWS     = 3,
    parameter int COLS     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    relu_pool_if.slave  bus
);
    localparam int NPOS_IN  = ROWS * COLS;
    localparam int NPOS_OUT = ROWS * (COLS / 2);
    localparam int CNT_W    = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                                   state_d,  state_q;
    logic [CNT_W-1:0]                         ch_cnt_d, ch_cnt_q;
    logic [CH-1:0][NPOS_IN-1:0][DATA_LEN-1:0]  buf_d,    buf_q;
    logic [CH-1:0][NPOS_OUT-1:0][DATA_LEN-1:0] out_d,    out_q;
    logic                                     valid_d,  valid_q;
    logic                                     busy_d,   busy_q;

    // max of two signed words, clamped at zero (ReLU after pooling is
    // equivalent to ReLU before it since max is monotonic)
    function automatic logic [DATA_LEN-1:0] relu_max2(
        input logic [DATA_LEN-1:0] a,
        input logic [DATA_LEN-1:0] b
    );
        logic [DATA_LEN-1:0] m;
        m = ($signed(a) > $signed(b)) ? a : b;
        if (m[DATA_LEN-1]) begin
            relu_max2 = {DATA_LEN{1'b0}};
        end else begin
            relu_max2 = m;
        end
    endfunction

    // next-state, capture and per-channel pooling logic
    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        buf_d    = buf_q;
        out_d    = out_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.load) begin
                    buf_d    = bus.d;
                    ch_cnt_d = {CNT_W{1'b0}};
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end else begin
                    state_d  = state_q;
                end
            end
            S_CALC: begin
                // only the current channel's slice is rewritten; others hold
                for (int r = 0; r < ROWS; r++) begin
                    for (int j = 0; j < COLS / 2; j++) begin
                        out_d[ch_cnt_q][r*(COLS/2)+j] =
                            relu_max2(buf_q[ch_cnt_q][r*COLS+2*j],
                                      buf_q[ch_cnt_q][r*COLS+2*j+1]);
                    end
                end
                ch_cnt_d = ch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (ch_cnt_q == CNT_W'(CH - 1)) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_CALC;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers; reset overrides everything, even mid-CALC
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            ch_cnt_q <= {CNT_W{1'b0}};
            buf_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
            buf_q    <= buf_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q     = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
endmodule

// File: doc/relu_pool.md
Name: relu_pool

Overview:
- Stage directly downstream of the convolution layer block; consumes its 32-channel x 12-position biased result once the layer asserts valid.
- Applies ReLU and 1x2 horizontal max pooling to each channel's 3x4 map, giving a 3x2 map per channel.
- Processes one channel per cycle through a small FSM, then presents the pooled feature map with a level valid for the next layer's load.

Parameters:
- DATA_LEN, 16, bit width of one signed two's-complement feature value.
- CH, 32, number of channels.
- ROWS, 3, feature-map rows.
- COLS, 4, feature-map columns; must be even.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (name kept per codebase, polarity is high).
- load  in  1  start pulse; normally driven by the layer's valid.
- d  in  CH*ROWS*COLS*DATA_LEN  input map; channel c, position p=r*COLS+col at bits [(c*ROWS*COLS+p)*DATA_LEN +: DATA_LEN].
- busy  out  1  high while in CALC.
- valid  out  1  high in DONE; q is complete and stable.
- q  out  CH*ROWS*(COLS/2)*DATA_LEN  output map; channel c, position o=r*(COLS/2)+j at bits [(c*ROWS*(COLS/2)+o)*DATA_LEN +: DATA_LEN].

Behaviour:
- States: IDLE, CALC, DONE. Reset forces IDLE, ch_cnt=0, input buffer=0, q=0, valid=0, busy=0.
- Reset has priority over every other event, including an active CALC; partial results are discarded and q clears to 0.
- IDLE or DONE with load=1 at edge E0:
  - capture d into the internal input buffer;
  - set ch_cnt=0, valid=0, busy=1;
  - go to CALC.
- CALC:
  - at each edge, compute channel ch_cnt from the buffer and write its ROWS*(COLS/2) output slice into q;
  - then increment ch_cnt;
  - at the edge where ch_cnt==CH-1, go to DONE, valid=1, busy=0.
- Latency: valid first high after edge E0+CH (32 clocks after the load edge). valid stays high until the next accepted load or reset.
- load during CALC is ignored: the buffer is not recaptured and the count continues.
- Output slices of channels not yet processed keep their previous values during CALC. Consumers use q only while valid=1.
- Arithmetic per output:
  - q[c][r][j] = max(0, max(x[c][r][2j], x[c][r][2j+1])), with signed comparison over DATA_LEN bits.
  - Equal inputs yield that value.
  - No width growth or saturation; the result is in [0, 2^(DATA_LEN-1)-1].
- The most negative value (0x8000 for DATA_LEN=16) maps to 0.
- d is sampled only at the accepted load edge; later changes on d have no effect.
- load in DONE restarts immediately: valid drops at that same edge.

Test Plan:
- Reset mid-CALC: load, run 10 cycles, rst_n=1 for one edge → IDLE, valid=0, busy=0, q=0; a new load then completes in 32 cycles.
- Basic pooling, channel 0 row 0 inputs {5, -3, -7, 2} → q[0][0][0]=5, q[0][0][1]=2. valid rises exactly 32 edges after the load edge; busy high for those 32 cycles.
- All-negative input, every value 0x8000 or -1 → every q word 0x0000 when valid.
- Equal and extreme values: pair {0x7FFF, 0x7FFF} → 0x7FFF; pair {0, 0} → 0; pair {-1, 0} → 0.
- Load during CALC: load with pattern A, assert load with pattern B at cycle 15 → result equals pattern A's pooling, valid at cycle 32. Load in DONE with pattern B → valid drops next edge and rises 32 edges later with B's result.
- Channel indexing: channel c filled with the constant value c+1 → every q word of channel c equals c+1. This checks slice ordering for c=0..31.
